// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor:
// 2-bit counter type, counter constants, FSM state enum and saturating arithmetic.
package bp_pkg;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CTR_SNT = 2'b00;
  localparam ctr2_t CTR_WNT = 2'b01;
  localparam ctr2_t CTR_WT  = 2'b10;
  localparam ctr2_t CTR_ST  = 2'b11;

  typedef enum logic {
    INIT,
    RUN
  } bp_state_t;

  function automatic ctr2_t sat_inc(input ctr2_t c);
    return (c == CTR_ST) ? CTR_ST : ctr2_t'(c + 2'd1);
  endfunction

  function automatic ctr2_t sat_dec(input ctr2_t c);
    return (c == CTR_SNT) ? CTR_SNT : ctr2_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bp_pht_ram.sv
// Pattern history table: 2**IDX_W x 2-bit storage, one synchronous read port
// and one write port, with write-first bypass when both hit the same entry.
module bp_pht_ram
  import bp_pkg::*;
#(
  parameter int IDX_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output ctr2_t            rdata,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  ctr2_t            wdata
);

  ctr2_t mem [2**IDX_W];
  ctr2_t rdata_q;
  ctr2_t rdata_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

  // NOTE: state flops use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= CTR_SNT;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the array is deliberately not reset; the INIT sweep establishes its contents after every reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/gshare_bp.sv
// Gshare direction predictor: speculative GHR XOR fetch-PC indexes a PHT of
// 2-bit counters; supports checkpoint recovery and a post-reset INIT sweep.
module gshare_bp
  import bp_pkg::*;
#(
  parameter int         GHR_W    = 12,
  parameter int         IDX_W    = 12,
  parameter int         PC_W     = 32,
  parameter int         PC_LSB   = 2,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_done,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_out_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  output logic [1:0]       pred_ctr,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [1:0]       upd_ctr,
  input  logic             upd_taken,
  input  logic             upd_mispredict,
  input  logic [GHR_W-1:0] upd_ghr
);

  function automatic logic [GHR_W-1:0] shift_in(input logic [GHR_W-1:0] h, input logic b);
    logic [GHR_W:0] tmp;
    tmp = {h, b};
    return tmp[GHR_W-1:0];
  endfunction

  bp_state_t        state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic             spec_pend_q, spec_pend_d;
  logic             init_done_q, init_done_d;
  logic             pred_out_valid_q, pred_out_valid_d;
  logic [IDX_W-1:0] pred_idx_q, pred_idx_d;
  logic [GHR_W-1:0] pred_ghr_q, pred_ghr_d;

  logic [GHR_W-1:0] ghr_cur;
  logic [IDX_W-1:0] pht_idx;
  logic             ram_re;
  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  ctr2_t            ram_wdata;
  ctr2_t            ram_rdata;
  logic             pc_unused;

  // The shift for last cycle's prediction is applied lazily, once its counter has been read.
  assign ghr_cur   = spec_pend_q ? shift_in(ghr_q, ram_rdata[1]) : ghr_q;
  assign pht_idx   = pred_pc[PC_LSB +: IDX_W] ^ IDX_W'(ghr_cur);
  assign pc_unused = ^pred_pc;

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    ghr_d            = ghr_cur;
    spec_pend_d      = 1'b0;
    pred_out_valid_d = 1'b0;
    pred_idx_d       = pred_idx_q;
    pred_ghr_d       = pred_ghr_q;
    ram_re           = 1'b0;
    ram_we           = 1'b0;
    ram_waddr        = ptr_q;
    ram_wdata        = ctr2_t'(CTR_INIT);

    case (state_q)
      INIT: begin
        ram_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (pred_valid) begin
          ram_re           = 1'b1;
          pred_out_valid_d = 1'b1;
          pred_idx_d       = pht_idx;
          pred_ghr_d       = ghr_cur;
          spec_pend_d      = 1'b1;
        end
        if (upd_valid) begin
          ram_we    = 1'b1;
          ram_waddr = upd_idx;
          ram_wdata = upd_taken ? sat_inc(ctr2_t'(upd_ctr)) : sat_dec(ctr2_t'(upd_ctr));
          if (upd_mispredict) begin
            ghr_d       = shift_in(upd_ghr, upd_taken);
            spec_pend_d = 1'b0;
          end
        end
      end
      default: state_d = INIT;
    endcase

    init_done_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= INIT;
      ptr_q            <= '0;
      ghr_q            <= '0;
      spec_pend_q      <= 1'b0;
      init_done_q      <= 1'b0;
      pred_out_valid_q <= 1'b0;
      pred_idx_q       <= '0;
      pred_ghr_q       <= '0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      ghr_q            <= ghr_d;
      spec_pend_q      <= spec_pend_d;
      init_done_q      <= init_done_d;
      pred_out_valid_q <= pred_out_valid_d;
      pred_idx_q       <= pred_idx_d;
      pred_ghr_q       <= pred_ghr_d;
    end
  end

  bp_pht_ram #(
    .IDX_W (IDX_W)
  ) u_pht (
    .clk   (clk),
    .rst   (rst),
    .re    (ram_re),
    .raddr (pht_idx),
    .rdata (ram_rdata),
    .we    (ram_we & rst),
    .waddr (ram_waddr),
    .wdata (ram_wdata)
  );

  assign init_done      = init_done_q;
  assign pred_out_valid = pred_out_valid_q;
  assign pred_taken     = ram_rdata[1];
  assign pred_idx       = pred_idx_q;
  assign pred_ctr       = ram_rdata;
  assign pred_ghr       = pred_ghr_q;

endmodule

// File: tb/tb_gshare_bp.sv
// Self-checking bench for gshare_bp (GHR_W=4, IDX_W=4): directed scenarios plus
// randomized traffic compared against an array-based reference model.
module tb_gshare_bp;

  localparam int GHR_W  = 4;
  localparam int IDX_W  = 4;
  localparam int PC_W   = 32;
  localparam int PC_LSB = 2;
  localparam int DEPTH  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             init_done;
  logic             pred_valid = 1'b0;
  logic [PC_W-1:0]  pred_pc = '0;
  logic             pred_out_valid;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_idx;
  logic [1:0]       pred_ctr;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid = 1'b0;
  logic [IDX_W-1:0] upd_idx = '0;
  logic [1:0]       upd_ctr = '0;
  logic             upd_taken = 1'b0;
  logic             upd_mispredict = 1'b0;
  logic [GHR_W-1:0] upd_ghr = '0;

  always #5 clk = ~clk;

  gshare_bp #(
    .GHR_W    (GHR_W),
    .IDX_W    (IDX_W),
    .PC_W     (PC_W),
    .PC_LSB   (PC_LSB),
    .CTR_INIT (2'b01)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .init_done      (init_done),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_out_valid (pred_out_valid),
    .pred_taken     (pred_taken),
    .pred_idx       (pred_idx),
    .pred_ctr       (pred_ctr),
    .pred_ghr       (pred_ghr),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_ctr        (upd_ctr),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .upd_ghr        (upd_ghr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_pht [DEPTH];
  int m_ghr = 0;
  int m_ptr = 0;
  bit m_run = 0;

  // Expected outputs after the most recent step
  bit exp_valid = 0;
  bit exp_done  = 0;
  int exp_idx   = 0;
  int exp_ctr   = 0;
  int exp_ghr   = 0;

  // Drive one cycle of inputs, advance the model, then sample just after the edge.
  task automatic step(input bit r, input bit pv, input logic [PC_W-1:0] pc,
                      input bit uv, input int uidx, input int uctr,
                      input bit ut, input bit um, input int ughr);
    int newv;
    int idx;
    rst            = r;
    pred_valid     = pv;
    pred_pc        = pc;
    upd_valid      = uv;
    upd_idx        = IDX_W'(uidx);
    upd_ctr        = 2'(uctr);
    upd_taken      = ut;
    upd_mispredict = um;
    upd_ghr        = GHR_W'(ughr);

    exp_valid = 0;
    if (!r) begin
      m_run = 0; m_ptr = 0; m_ghr = 0;
      exp_idx = 0; exp_ctr = 0; exp_ghr = 0;
    end else if (!m_run) begin
      m_pht[m_ptr] = 1;
      m_ptr++;
      if (m_ptr == DEPTH) m_run = 1;
    end else begin
      newv = ut ? ((uctr >= 3) ? 3 : uctr + 1) : ((uctr <= 0) ? 0 : uctr - 1);
      if (pv) begin
        idx       = (int'(pc >> PC_LSB) % DEPTH) ^ m_ghr;
        exp_valid = 1;
        exp_idx   = idx;
        exp_ctr   = (uv && uidx == idx) ? newv : m_pht[idx];
        exp_ghr   = m_ghr;
      end
      if (uv) m_pht[uidx] = newv;
      if (uv && um) m_ghr = (ughr * 2 + int'(ut)) % (1 << GHR_W);
      else if (pv)  m_ghr = (m_ghr * 2 + exp_ctr / 2) % (1 << GHR_W);
    end
    exp_done = m_run;

    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1, 0, '0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic predict(input logic [PC_W-1:0] pc);
    step(1, 1, pc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(0, 0, '0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h10, 1, 4, 3, 1, 1, 5);
    n_tests++;
    if ({init_done, pred_out_valid, pred_taken, pred_idx, pred_ctr, pred_ghr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got done=%0b v=%0b t=%0b idx=%0h ctr=%0h ghr=%0h required all 0",
               init_done, pred_out_valid, pred_taken, pred_idx, pred_ctr, pred_ghr);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 1, $urandom, 1, $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom), 1, $urandom_range(0, 15));
      n_tests++;
      if (init_done !== (i == DEPTH - 1)) begin
        n_fail++;
        $display("FAIL init_done_cycle%0d: got %0b required %0b", i + 1, init_done, (i == DEPTH - 1));
      end
      n_tests++;
      if (pred_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL init_no_pred_cycle%0d: got %0b required 0", i + 1, pred_out_valid);
      end
    end
  endtask

  task automatic test_basic_predict();
    predict(32'h10);
    n_tests++;
    if ({pred_out_valid, pred_idx, pred_ctr, pred_taken, pred_ghr} !== {1'b1, 4'd4, 2'b01, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL basic_pred: got v=%0b idx=%0d ctr=%0b t=%0b ghr=%0h required v=1 idx=4 ctr=01 t=0 ghr=0",
               pred_out_valid, pred_idx, pred_ctr, pred_taken, pred_ghr);
    end
    idle();
    n_tests++;
    if (pred_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pred_pulse: got %0b required 0", pred_out_valid);
    end
    predict(32'h0);
    n_tests++;
    if ({pred_idx, pred_ghr} !== {4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL ghr_after_nt: got idx=%0d ghr=%0h required idx=0 ghr=0", pred_idx, pred_ghr);
    end
  endtask

  task automatic test_saturation();
    step(1, 0, '0, 1, 4, 1, 1, 0, 0);
    step(1, 0, '0, 1, 4, 2, 1, 0, 0);
    step(1, 0, '0, 1, 4, 3, 1, 0, 0);
    predict(32'h10);
    n_tests++;
    if ({pred_idx, pred_ctr, pred_taken} !== {4'd4, 2'b11, 1'b1}) begin
      n_fail++;
      $display("FAIL saturate: got idx=%0d ctr=%0b t=%0b required idx=4 ctr=11 t=1",
               pred_idx, pred_ctr, pred_taken);
    end
  endtask

  task automatic test_history();
    step(1, 0, '0, 1, 15, 1, 0, 1, 0);
    predict(32'h10);
    n_tests++;
    if ({pred_idx, pred_taken, pred_ghr} !== {4'd4, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL hist_t1: got idx=%0d t=%0b ghr=%0h required idx=4 t=1 ghr=0", pred_idx, pred_taken, pred_ghr);
    end
    predict(32'h14);
    n_tests++;
    if ({pred_idx, pred_taken, pred_ghr} !== {4'd4, 1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL hist_t2: got idx=%0d t=%0b ghr=%0h required idx=4 t=1 ghr=1", pred_idx, pred_taken, pred_ghr);
    end
    predict(32'h0C);
    n_tests++;
    if ({pred_idx, pred_taken, pred_ghr} !== {4'd0, 1'b0, 4'd3}) begin
      n_fail++;
      $display("FAIL hist_nt3: got idx=%0d t=%0b ghr=%0h required idx=0 t=0 ghr=3", pred_idx, pred_taken, pred_ghr);
    end
    predict(32'h0);
    n_tests++;
    if (pred_ghr !== 4'b0110) begin
      n_fail++;
      $display("FAIL hist_ghr110: got %0h required 6", pred_ghr);
    end
    step(1, 0, '0, 1, 9, 1, 1, 1, 1);
    predict(32'h0);
    n_tests++;
    if (pred_ghr !== 4'b0011) begin
      n_fail++;
      $display("FAIL recover_011: got %0h required 3", pred_ghr);
    end
  endtask

  task automatic test_recovery_priority();
    step(1, 1, 32'h20, 1, 10, 1, 0, 1, 5);
    n_tests++;
    if ({pred_out_valid, pred_idx, pred_ghr} !== {1'b1, 4'(exp_idx), 4'(exp_ghr)}) begin
      n_fail++;
      $display("FAIL prio_pred: got v=%0b idx=%0d ghr=%0h required v=1 idx=%0d ghr=%0h",
               pred_out_valid, pred_idx, pred_ghr, exp_idx, exp_ghr);
    end
    predict(32'h0);
    n_tests++;
    if (pred_ghr !== 4'b1010) begin
      n_fail++;
      $display("FAIL prio_ghr: got %0h required a", pred_ghr);
    end
  endtask

  task automatic test_bypass();
    logic [PC_W-1:0] pc;
    pc = PC_W'((7 ^ m_ghr) << PC_LSB);
    step(1, 1, pc, 1, 7, 2, 1, 0, 0);
    n_tests++;
    if ({pred_idx, pred_ctr, pred_taken} !== {4'd7, 2'b11, 1'b1}) begin
      n_fail++;
      $display("FAIL bypass_inc: got idx=%0d ctr=%0b t=%0b required idx=7 ctr=11 t=1", pred_idx, pred_ctr, pred_taken);
    end
    pc = PC_W'((7 ^ m_ghr) << PC_LSB);
    step(1, 1, pc, 1, 7, 1, 0, 0, 0);
    n_tests++;
    if ({pred_idx, pred_ctr, pred_taken} !== {4'd7, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL bypass_dec: got idx=%0d ctr=%0b t=%0b required idx=7 ctr=00 t=0", pred_idx, pred_ctr, pred_taken);
    end
  endtask

  task automatic test_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step(1, ($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 5),
           $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 15));
      n_tests++;
      if (pred_out_valid !== exp_valid || init_done !== exp_done) begin
        n_fail++;
        $display("FAIL rand_valid_%0d: got v=%0b done=%0b required v=%0b done=%0b",
                 i, pred_out_valid, init_done, exp_valid, exp_done);
      end
      if (exp_valid) begin
        n_tests++;
        if ({pred_idx, pred_ctr, pred_taken, pred_ghr} !== {4'(exp_idx), 2'(exp_ctr), 1'(exp_ctr / 2), 4'(exp_ghr)}) begin
          n_fail++;
          $display("FAIL rand_pred_%0d: got idx=%0d ctr=%0d t=%0b ghr=%0h required idx=%0d ctr=%0d t=%0b ghr=%0h",
                   i, pred_idx, pred_ctr, pred_taken, pred_ghr, exp_idx, exp_ctr, exp_ctr / 2, exp_ghr);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    test_random(10);
    step(0, 1, 32'h3C, 1, 3, 2, 1, 1, 7);
    n_tests++;
    if ({init_done, pred_out_valid, pred_taken, pred_idx, pred_ctr, pred_ghr} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: got done=%0b v=%0b t=%0b idx=%0h ctr=%0h ghr=%0h required all 0",
               init_done, pred_out_valid, pred_taken, pred_idx, pred_ctr, pred_ghr);
    end
    for (int i = 0; i < 5; i++) predict($urandom);
    step(0, 0, '0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      predict($urandom);
      n_tests++;
      if (init_done !== (i == DEPTH - 1) || pred_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reinit_cycle%0d: got done=%0b v=%0b required done=%0b v=0",
                 i + 1, init_done, pred_out_valid, (i == DEPTH - 1));
      end
    end
    predict(32'h10);
    n_tests++;
    if ({pred_out_valid, pred_idx, pred_ctr, pred_ghr} !== {1'b1, 4'd4, 2'b01, 4'd0}) begin
      n_fail++;
      $display("FAIL reinit_pred: got v=%0b idx=%0d ctr=%0b ghr=%0h required v=1 idx=4 ctr=01 ghr=0",
               pred_out_valid, pred_idx, pred_ctr, pred_ghr);
    end
  endtask

  initial begin
    test_reset();
    test_basic_predict();
    test_saturation();
    test_history();
    test_recovery_priority();
    test_bypass();
    test_random(400);
    test_reset_midstream();
    test_random(100);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
